// File: rtl/pen_filter.sv
// pen_filter: cleans up raw IR-blob camera coordinates for the drawing stage.
//   - Drops "no blob" samples (x or y >= 1023).
//   - Smooths hits with a 2^LOG2_AVG-deep moving average per axis.
//   - Tracks pen-up/pen-down: MISS_LIMIT consecutive misses lift the pen.
//   - Presents each averaged hit on a valid/ready holding register, two
//     cycles after the in_valid strobe. A result that overwrites an
//     unaccepted one sets the sticky overrun flag.
// Optional feature: define PEN_JUMP_REJECT_EN to treat a hit that lies more
//   than JUMP_MAX from the current average (on either axis) as a miss.
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   in_valid   one-cycle strobe, x/y carry a camera sample
//   x, y       raw camera coordinates (11 bits)
//   out_valid  holding register holds a filtered sample
//   out_ready  consumer accepts when out_valid & out_ready
//   out_x/y    averaged coordinates (10 bits)
//   pen_down   1 while a blob is being tracked
//   overrun    sticky, an unaccepted result was overwritten
module pen_filter #(
    parameter int unsigned LOG2_AVG   = 2,
    parameter int unsigned MISS_LIMIT = 4,
    parameter int unsigned JUMP_MAX   = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [10:0] x,
    input  logic [10:0] y,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [9:0]  out_x,
    output logic [9:0]  out_y,
    output logic        pen_down,
    output logic        overrun
);

    localparam int unsigned DEPTH = 1 << LOG2_AVG;
    localparam int unsigned SW    = 10 + LOG2_AVG;
    localparam int unsigned PW    = LOG2_AVG;
    localparam int unsigned CW    = 4;
    localparam logic [10:0] NO_BLOB = 11'd1023;

    typedef enum logic {
        ST_UP   = 1'b0,
        ST_DOWN = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   miss_cnt_q, miss_cnt_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [SW-1:0]   sum_x_q, sum_x_d;
    logic [SW-1:0]   sum_y_q, sum_y_d;
    logic [9:0]      win_x_q [DEPTH];
    logic [9:0]      win_x_d [DEPTH];
    logic [9:0]      win_y_q [DEPTH];
    logic [9:0]      win_y_d [DEPTH];
    logic            res_vld_q, res_vld_d;
    logic            pen_down_q, pen_down_d;
    logic            out_valid_q, out_valid_d;
    logic [9:0]      out_x_q, out_x_d;
    logic [9:0]      out_y_q, out_y_d;
    logic            overrun_q, overrun_d;

    logic            blob_c;
    logic            jump_c;
    logic            hit_c;
    logic            miss_c;
    logic [9:0]      smp_x_c;
    logic [9:0]      smp_y_c;

    // Sample classification: only the low 10 bits carry a valid coordinate.
    assign smp_x_c = x[9:0];
    assign smp_y_c = y[9:0];
    assign blob_c  = (x < NO_BLOB) && (y < NO_BLOB);

`ifdef PEN_JUMP_REJECT_EN
    logic [9:0] avg_x_c, avg_y_c;
    logic [9:0] dx_c, dy_c;

    // Distance from the current window average; only meaningful while tracking.
    always_comb begin
        avg_x_c = 10'(sum_x_q >> LOG2_AVG);
        avg_y_c = 10'(sum_y_q >> LOG2_AVG);
        dx_c    = (smp_x_c > avg_x_c) ? (smp_x_c - avg_x_c) : (avg_x_c - smp_x_c);
        dy_c    = (smp_y_c > avg_y_c) ? (smp_y_c - avg_y_c) : (avg_y_c - smp_y_c);
        jump_c  = (state_q == ST_DOWN) &&
                  (({1'b0, dx_c} > 11'(JUMP_MAX)) || ({1'b0, dy_c} > 11'(JUMP_MAX)));
    end
`else
    logic [31:0] unused_jump_max;

    assign unused_jump_max = 32'(JUMP_MAX);
    assign jump_c          = 1'b0;
`endif

    assign hit_c  = in_valid && blob_c && !jump_c;
    assign miss_c = in_valid && !hit_c;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_UP;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, window and running-sum update (stage 1).
    always_comb begin
        state_d    = state_q;
        miss_cnt_d = miss_cnt_q;
        ptr_d      = ptr_q;
        sum_x_d    = sum_x_q;
        sum_y_d    = sum_y_q;
        win_x_d    = win_x_q;
        win_y_d    = win_y_q;
        res_vld_d  = 1'b0;

        case (state_q)
            ST_UP: begin
                // First hit pre-fills the whole window so the average starts exact.
                if (hit_c) begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        win_x_d[PW'(i)] = smp_x_c;
                        win_y_d[PW'(i)] = smp_y_c;
                    end
                    sum_x_d    = SW'(smp_x_c) << LOG2_AVG;
                    sum_y_d    = SW'(smp_y_c) << LOG2_AVG;
                    ptr_d      = '0;
                    miss_cnt_d = '0;
                    res_vld_d  = 1'b1;
                    state_d    = ST_DOWN;
                end
            end
            ST_DOWN: begin
                if (hit_c) begin
                    // ptr_q always points at the oldest slot.
                    win_x_d[ptr_q] = smp_x_c;
                    win_y_d[ptr_q] = smp_y_c;
                    sum_x_d    = sum_x_q + SW'(smp_x_c) - SW'(win_x_q[ptr_q]);
                    sum_y_d    = sum_y_q + SW'(smp_y_c) - SW'(win_y_q[ptr_q]);
                    ptr_d      = ptr_q + PW'(1);
                    miss_cnt_d = '0;
                    res_vld_d  = 1'b1;
                end else if (miss_c) begin
                    if (miss_cnt_q == CW'(MISS_LIMIT - 1)) begin
                        miss_cnt_d = '0;
                        state_d    = ST_UP;
                    end else begin
                        miss_cnt_d = miss_cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_UP;
            end
        endcase

        pen_down_d = (state_d == ST_DOWN);
    end

    // Output holding register (stage 2).
    always_comb begin
        out_valid_d = out_valid_q;
        out_x_d     = out_x_q;
        out_y_d     = out_y_q;
        overrun_d   = overrun_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        // A new result wins over a same-cycle transfer clear.
        if (res_vld_q) begin
            out_valid_d = 1'b1;
            out_x_d     = 10'(sum_x_q >> LOG2_AVG);
            out_y_d     = 10'(sum_y_q >> LOG2_AVG);
            if (out_valid_q && !out_ready) begin
                overrun_d = 1'b1;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            miss_cnt_q  <= '0;
            ptr_q       <= '0;
            sum_x_q     <= '0;
            sum_y_q     <= '0;
            win_x_q     <= '{default: '0};
            win_y_q     <= '{default: '0};
            res_vld_q   <= 1'b0;
            pen_down_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            overrun_q   <= 1'b0;
        end else begin
            miss_cnt_q  <= miss_cnt_d;
            ptr_q       <= ptr_d;
            sum_x_q     <= sum_x_d;
            sum_y_q     <= sum_y_d;
            win_x_q     <= win_x_d;
            win_y_q     <= win_y_d;
            res_vld_q   <= res_vld_d;
            pen_down_q  <= pen_down_d;
            out_valid_q <= out_valid_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign pen_down  = pen_down_q;
    assign overrun   = overrun_q;

endmodule
